// File: rtl/encoder_74hc148_scan.sv
// encoder_74hc148_scan: registered, debounced 8-to-3 priority encoder with
// 74HC148-style active-low outputs and a one-cycle key-event strobe.
// Raw active-low pins are resynchronised, debounced into an accepted vector
// (acc), priority-encoded and presented on registered outputs.
module encoder_74hc148_scan #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       En,
  input  logic [7:0] IN_N,
  output logic [2:0] A_N,
  output logic       GSN,
  output logic       EON,
  output logic       key_evt,
  output logic [2:0] key_code
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  logic [7:0]       sync1;
  logic [7:0]       sync2;
  state_t           state;
  logic [7:0]       cand;
  logic [7:0]       acc;
  logic [CNT_W-1:0] cnt;

  logic             any;
  logic [2:0]       idx;

  logic             prev_any;
  logic [2:0]       prev_idx;
  logic             prev_en;
  logic             new_code;

  // Two-flop synchroniser bringing the asynchronous pins into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 8'hFF;
      sync2 <= 8'hFF;
    end else begin
      sync1 <= IN_N;
      sync2 <= sync1;
    end
  end

  // Debounce FSM: a changed vector must hold for DEBOUNCE_CYCLES cycles before it is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cand  <= 8'hFF;
      acc   <= 8'hFF;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sync2 != acc) begin
            cand  <= sync2;
            cnt   <= CNT_ONE;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (sync2 != cand) begin
            // Input moved again: restart the stability window on the new value
            cand <= sync2;
            cnt  <= CNT_ONE;
          end else if (cnt == CNT_LAST) begin
            acc   <= cand;
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Priority encode the accepted vector; later (higher) bits override lower ones
  always_comb begin
    any = ~&acc;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!acc[i]) begin
        idx = 3'(i);
      end
    end
  end

  // A press is new if the code changed since last cycle or the block was just enabled
  assign new_code = ({any, idx} != {prev_any, prev_idx}) || !prev_en;

  // Registered 74HC148-style outputs, key-event strobe and previous-code tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A_N      <= 3'b111;
      GSN      <= 1'b1;
      EON      <= 1'b1;
      key_evt  <= 1'b0;
      key_code <= 3'b000;
      prev_any <= 1'b0;
      prev_idx <= 3'b000;
      prev_en  <= 1'b0;
    end else begin
      prev_any <= any;
      prev_idx <= idx;
      prev_en  <= En;
      key_evt  <= 1'b0;
      if (!En) begin
        A_N <= 3'b111;
        GSN <= 1'b1;
        EON <= 1'b1;
      end else if (any) begin
        A_N <= ~idx;
        GSN <= 1'b0;
        EON <= 1'b1;
        if (new_code) begin
          key_evt  <= 1'b1;
          key_code <= idx;
        end
      end else begin
        A_N <= 3'b111;
        GSN <= 1'b1;
        EON <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_encoder_74hc148_scan.sv
// tb_encoder_74hc148_scan: table-driven, scoreboarded bench for the debounced
// priority encoder, run with a short debounce window.
module tb_encoder_74hc148_scan;

  localparam int DEB = 4;
  localparam int CW  = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b1;
  logic [7:0] in_n  = 8'hFF;
  logic [2:0] a_n;
  logic       gsn;
  logic       eon;
  logic       key_evt;
  logic [2:0] key_code;

  typedef struct {
    logic [7:0] in_n;
    logic       en;
    int         cycles;
    logic [2:0] a_n;
    logic       gsn;
    logic       eon;
    int         evts;
    logic [2:0] code;
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];

  int   checks   = 0;
  int   failures = 0;
  int   evt_seen = 0;
  logic last_evt = 1'b0;
  logic [2:0] last_code = 3'b000;

  encoder_74hc148_scan #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .En(en),
    .IN_N(in_n),
    .A_N(a_n),
    .GSN(gsn),
    .EON(eon),
    .key_evt(key_evt),
    .key_code(key_code)
  );

  always #5 clk = ~clk;

  // Compare one observed value against the bench's expectation
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock edge, sample just after it, and tally key events
  task automatic tick();
    @(posedge clk);
    #1;
    if (key_evt === 1'b1) evt_seen++;
    if (key_evt === 1'b1 && last_evt === 1'b1 && key_code === last_code) begin
      checks++;
      failures++;
      $display("[TB] FAIL repeat_evt: key_evt high twice for code %0d, expected single pulse", key_code);
    end
    last_evt  = key_evt;
    last_code = key_code;
  endtask

  // Drive one record, push its expectation, run its window, then pop and compare
  task automatic applyStimulus(input vec_t v, input string tag);
    vec_t e;
    in_n = v.in_n;
    en   = v.en;
    sb_q.push_back(v);
    evt_seen = 0;
    repeat (v.cycles) tick();
    e = sb_q.pop_front();
    checkOutput($sformatf("%s.a_n", tag), 32'(a_n), 32'(e.a_n));
    checkOutput($sformatf("%s.gsn", tag), 32'(gsn), 32'(e.gsn));
    checkOutput($sformatf("%s.eon", tag), 32'(eon), 32'(e.eon));
    checkOutput($sformatf("%s.evts", tag), 32'(evt_seen), 32'(e.evts));
    checkOutput($sformatf("%s.code", tag), 32'(key_code), 32'(e.code));
  endtask

  function automatic vec_t mk(input logic [7:0] i, input logic e, input int c,
                              input logic [2:0] a, input logic g, input logic o,
                              input int n, input logic [2:0] k);
    vec_t v;
    v.in_n = i; v.en = e; v.cycles = c; v.a_n = a;
    v.gsn = g; v.eon = o; v.evts = n; v.code = k;
    return v;
  endfunction

  initial begin
    // Main vector table: each record runs long enough for debounce plus output register
    vecs.push_back(mk(8'hBB, 1'b1, 10, 3'b001, 1'b0, 1'b1, 1, 3'd6));
    vecs.push_back(mk(8'hBF, 1'b1, 10, 3'b001, 1'b0, 1'b1, 0, 3'd6));
    vecs.push_back(mk(8'hFF, 1'b1, 10, 3'b111, 1'b1, 1'b0, 0, 3'd6));
    vecs.push_back(mk(8'h7F, 1'b1, 10, 3'b000, 1'b0, 1'b1, 1, 3'd7));
    vecs.push_back(mk(8'h7F, 1'b0,  3, 3'b111, 1'b1, 1'b1, 0, 3'd7));
    vecs.push_back(mk(8'h7F, 1'b1,  3, 3'b000, 1'b0, 1'b1, 1, 3'd7));
    vecs.push_back(mk(8'h7F, 1'b1,  3, 3'b000, 1'b0, 1'b1, 0, 3'd7));
    vecs.push_back(mk(8'hFE, 1'b1, 10, 3'b111, 1'b0, 1'b1, 1, 3'd0));
    vecs.push_back(mk(8'hFF, 1'b0, 10, 3'b111, 1'b1, 1'b1, 0, 3'd0));
    vecs.push_back(mk(8'hEF, 1'b0, 10, 3'b111, 1'b1, 1'b1, 0, 3'd0));
    vecs.push_back(mk(8'hEF, 1'b1,  3, 3'b011, 1'b0, 1'b1, 1, 3'd4));
    vecs.push_back(mk(8'h00, 1'b1, 10, 3'b000, 1'b0, 1'b1, 1, 3'd7));
    vecs.push_back(mk(8'hD5, 1'b1, 10, 3'b010, 1'b0, 1'b1, 1, 3'd5));
    vecs.push_back(mk(8'hFF, 1'b1, 10, 3'b111, 1'b1, 1'b0, 0, 3'd5));
    // Glitch one cycle short of the window is rejected; exactly the window is accepted
    vecs.push_back(mk(8'hFE, 1'b1, DEB-1, 3'b111, 1'b1, 1'b0, 0, 3'd5));
    vecs.push_back(mk(8'hFF, 1'b1, 10,    3'b111, 1'b1, 1'b0, 0, 3'd5));
    vecs.push_back(mk(8'hFE, 1'b1, DEB,   3'b111, 1'b1, 1'b0, 0, 3'd5));
    vecs.push_back(mk(8'hFF, 1'b1, 14,    3'b111, 1'b1, 1'b0, 1, 3'd0));

    // Reset values while rst_n is held low
    #12;
    checkOutput("rst.a_n", 32'(a_n), 32'h7);
    checkOutput("rst.gsn", 32'(gsn), 32'h1);
    checkOutput("rst.eon", 32'(eon), 32'h1);
    checkOutput("rst.evt", 32'(key_evt), 32'h0);
    checkOutput("rst.code", 32'(key_code), 32'h0);
    rst_n = 1'b1;
    evt_seen = 0;
    tick();
    checkOutput("idle.a_n", 32'(a_n), 32'h7);
    checkOutput("idle.gsn", 32'(gsn), 32'h1);
    checkOutput("idle.eon", 32'(eon), 32'h0);
    checkOutput("idle.evt", 32'(key_evt), 32'h0);

    // Exact latency: input 2 reaches the outputs on the seventh edge after driving
    in_n = 8'hFB;
    evt_seen = 0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 6) begin
        checkOutput("lat.early_evts", 32'(evt_seen), 32'h0);
        checkOutput("lat.early_a_n", 32'(a_n), 32'h7);
      end
    end
    checkOutput("lat.a_n", 32'(a_n), 32'h5);
    checkOutput("lat.gsn", 32'(gsn), 32'h0);
    checkOutput("lat.eon", 32'(eon), 32'h1);
    checkOutput("lat.evt", 32'(key_evt), 32'h1);
    checkOutput("lat.code", 32'(key_code), 32'h2);
    tick();
    checkOutput("lat.evt_drop", 32'(key_evt), 32'h0);

    foreach (vecs[i]) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Bounce on input 0 every 2 cycles for 20 cycles never reaches the outputs
    for (int i = 0; i < 10; i++) begin
      applyStimulus(mk((i % 2 == 0) ? 8'hFE : 8'hFF, 1'b1, 2,
                       3'b111, 1'b1, 1'b0, 0, 3'd0), $sformatf("bounce%0d", i));
    end
    applyStimulus(mk(8'hFF, 1'b1, 10, 3'b111, 1'b1, 1'b0, 0, 3'd0), "bounce_end");
    applyStimulus(mk(8'hFE, 1'b1, 10, 3'b111, 1'b0, 1'b1, 1, 3'd0), "bounce_hold");

    // Reset during SETTLE discards the candidate; input 3 is re-debounced from scratch
    in_n = 8'hF7;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst.a_n", 32'(a_n), 32'h7);
    checkOutput("mid_rst.gsn", 32'(gsn), 32'h1);
    checkOutput("mid_rst.eon", 32'(eon), 32'h1);
    checkOutput("mid_rst.evt", 32'(key_evt), 32'h0);
    checkOutput("mid_rst.code", 32'(key_code), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    evt_seen = 0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 6) begin
        checkOutput("post_rst.early_evts", 32'(evt_seen), 32'h0);
        checkOutput("post_rst.early_a_n", 32'(a_n), 32'h7);
      end
    end
    checkOutput("post_rst.a_n", 32'(a_n), 32'h4);
    checkOutput("post_rst.gsn", 32'(gsn), 32'h0);
    checkOutput("post_rst.eon", 32'(eon), 32'h1);
    checkOutput("post_rst.evt", 32'(key_evt), 32'h1);
    checkOutput("post_rst.code", 32'(key_code), 32'h3);
    tick();
    checkOutput("post_rst.evt_drop", 32'(key_evt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
